// File: rtl/simon_sequencer.sv
// Simon game controller: seeds the LFSR, replays the colour sequence, checks presses.
// Optional macro SIMON_TIMEOUT_EN adds a per-press timeout in IN_WAIT.
module simon_sequencer #(
  parameter int MAX_LEN       = 16,
  parameter int ON_TICKS      = 4,
  parameter int OFF_TICKS     = 2,
  parameter int TICK_W        = 24,
  parameter int TIMEOUT_TICKS = 1000,
  localparam int RW           = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    btn,
  input  logic [3:0]    lfsr_random,
  output logic          lfsr_step,
  output logic          lfsr_rerun,
  output logic          lfsr_randomize,
  output logic [3:0]    led,
  output logic [RW-1:0] round,
  output logic          busy,
  output logic          win,
  output logic          lose
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SEED   = 4'd1;
  localparam logic [3:0] S_PRERUN = 4'd2;
  localparam logic [3:0] S_PLOAD  = 4'd3;
  localparam logic [3:0] S_PON    = 4'd4;
  localparam logic [3:0] S_POFF   = 4'd5;
  localparam logic [3:0] S_IRERUN = 4'd6;
  localparam logic [3:0] S_IWAIT  = 4'd7;
  localparam logic [3:0] S_WIN    = 4'd8;
  localparam logic [3:0] S_LOSE   = 4'd9;

  localparam logic [TICK_W-1:0] T_ONE    = TICK_W'(1);
  localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);
  localparam logic [RW-1:0]     R_ONE    = RW'(1);
  localparam logic [RW-1:0]     LEN_MAX  = RW'(MAX_LEN);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [TICK_W-1:0] TO_LAST  = TICK_W'(TIMEOUT_TICKS - 1);
`endif

  logic [3:0]        state, state_d;
  logic [TICK_W-1:0] cnt, cnt_d;
  logic [RW-1:0]     idx, idx_d;
  logic [RW-1:0]     round_d;
  logic [3:0]        col, col_d;
  logic [3:0]        want;
  logic              step_d;
  logic              last;
  logic              unused_ok;

  assign want      = 4'b0001 << lfsr_random[1:0];
  assign last      = (idx + R_ONE) == round;
  assign unused_ok = ^{lfsr_random[3:2], TIMEOUT_TICKS[0]};

  // Next-state decode; a round advance after a press spends one
  // extra PLAY_RERUN cycle so the step and rerun pulses never overlap.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    round_d = round;
    col_d   = col;
    step_d  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEED;
          round_d = R_ONE;
          cnt_d   = '0;
        end
      end
      S_SEED: begin
        if (cnt == T_ONE) begin
          state_d = S_PRERUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + T_ONE;
        end
      end
      S_PRERUN: begin
        idx_d = '0;
        if (lfsr_rerun) state_d = S_PLOAD;
      end
      S_PLOAD: begin
        col_d   = want;
        cnt_d   = '0;
        state_d = S_PON;
      end
      S_PON: begin
        if (cnt == ON_LAST) begin
          cnt_d   = '0;
          state_d = S_POFF;
        end else begin
          cnt_d = cnt + T_ONE;
        end
      end
      S_POFF: begin
        if (cnt == OFF_LAST) begin
          idx_d   = idx + R_ONE;
          cnt_d   = '0;
          state_d = last ? S_IRERUN : S_PLOAD;
        end else begin
          cnt_d = cnt + T_ONE;
        end
      end
      S_IRERUN: begin
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_IWAIT;
      end
      S_IWAIT: begin
        if (btn == 4'b0000) begin
`ifdef SIMON_TIMEOUT_EN
          if (cnt == TO_LAST) state_d = S_LOSE;
          else cnt_d = cnt + T_ONE;
`endif
        end else if (btn == want) begin
          step_d = 1'b1;
          idx_d  = idx + R_ONE;
          cnt_d  = '0;
          if (last) begin
            if (round == LEN_MAX) begin
              state_d = S_WIN;
            end else begin
              round_d = round + R_ONE;
              state_d = S_PRERUN;
            end
          end
        end else begin
          state_d = S_LOSE;
        end
      end
      S_WIN, S_LOSE: begin
        if (start) begin
          state_d = S_IDLE;
          round_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_POFF && cnt_d == OFF_LAST) step_d = 1'b1;
  end

  // State, datapath and outputs registered from the next-state values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= '0;
      round          <= '0;
      col            <= '0;
      lfsr_step      <= 1'b0;
      lfsr_rerun     <= 1'b0;
      lfsr_randomize <= 1'b0;
      led            <= '0;
      busy           <= 1'b0;
      win            <= 1'b0;
      lose           <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      idx            <= idx_d;
      round          <= round_d;
      col            <= col_d;
      lfsr_step      <= step_d;
      lfsr_rerun     <= (state_d == S_PRERUN || state_d == S_IRERUN) && !step_d;
      lfsr_randomize <= state_d == S_IDLE;
      led            <= (state_d == S_PON) ? col_d :
                        (state_d == S_WIN) ? 4'b1111 : 4'b0000;
      busy           <= !(state_d == S_IDLE || state_d == S_WIN || state_d == S_LOSE);
      win            <= state_d == S_WIN;
      lose           <= state_d == S_LOSE;
    end
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer with a scripted LFSR model.
// Playback colours are scoreboarded; covers SIMON_TIMEOUT_EN both ways.
module tb_simon_sequencer;

  localparam int ML  = 2;
  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int TO  = 10;
  localparam int RW  = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    btn = 4'b0000;
  logic [3:0]    lfsr_random;
  logic          lfsr_step;
  logic          lfsr_rerun;
  logic          lfsr_randomize;
  logic [3:0]    led;
  logic [RW-1:0] round;
  logic          busy;
  logic          win;
  logic          lose;

  int         checks = 0;
  int         errors = 0;
  int         conflicts = 0;
  bit         chk_en = 1'b1;
  logic [7:0] ptr;
  logic [3:0] exp_q[$];

  simon_sequencer #(
    .MAX_LEN(ML),
    .ON_TICKS(ON),
    .OFF_TICKS(OFF),
    .TICK_W(24),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .btn(btn),
    .lfsr_random(lfsr_random),
    .lfsr_step(lfsr_step),
    .lfsr_rerun(lfsr_rerun),
    .lfsr_randomize(lfsr_randomize),
    .led(led),
    .round(round),
    .busy(busy),
    .win(win),
    .lose(lose)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] colour(input int i);
    case (i % 4)
      0: return 2'd2;
      1: return 2'd0;
      2: return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  assign lfsr_random = {2'b00, colour(int'(ptr))};

  // Scripted LFSR: rerun rewinds, step advances, randomize ignored.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else begin
      if (chk_en && lfsr_step && lfsr_rerun) conflicts <= conflicts + 1;
      if (lfsr_rerun) ptr <= '0;
      else if (lfsr_step) ptr <= ptr + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] v);
    btn = v;
    @(negedge clk);
    btn = 4'b0000;
  endtask

  // Watch one full playback of n colours; returns in the first IN_WAIT cycle.
  task automatic play_round(input int n, input logic [3:0] noise);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0001 << colour(i));
    for (int i = 0; i < n; i++) begin
      int t = 0;
      int on = 0;
      int off = 1;
      while (led == 4'b0000 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("play_led", led, exp_q.pop_front());
      while (led != 4'b0000 && on < 20) begin
        on++;
        btn = (on == 2) ? noise : 4'b0000;
        @(negedge clk);
      end
      btn = 4'b0000;
      chk("on_len", on, ON);
      while (!lfsr_step && off < 20) begin
        @(negedge clk);
        off++;
      end
      chk("off_len", off, OFF);
      chk("off_dark", led, 0);
      @(negedge clk);
      chk("step_once", lfsr_step, 0);
      if (i == n - 1) begin
        chk("in_rerun", lfsr_rerun, 1);
        @(negedge clk);
        chk("in_wait_busy", busy, 1);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs", {lfsr_step, lfsr_rerun, lfsr_randomize, led, busy, win, lose}, 0);
    chk("rst_round", round, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_rand", lfsr_randomize, 1);
    chk("idle_busy", busy, 0);

    pulse_start();
    chk("seed_rand", lfsr_randomize, 0);
    chk("seed_busy", busy, 1);
    chk("seed_round", round, 1);
    chk("seed1_rerun", lfsr_rerun, 0);
    @(negedge clk);
    chk("seed2_rerun", lfsr_rerun, 0);
    @(negedge clk);
    chk("rerun", lfsr_rerun, 1);
    chk("rerun_step", lfsr_step, 0);
    @(negedge clk);
    chk("load_led", led, 0);
    chk("load_rerun", lfsr_rerun, 0);
    play_round(1, 4'b0000);

    press(4'b0100);
    chk("p1_step", lfsr_step, 1);
    chk("p1_round", round, 2);
    chk("p1_rerun", lfsr_rerun, 0);
    @(negedge clk);
    chk("p1_rerun2", lfsr_rerun, 1);
    chk("p1_step2", lfsr_step, 0);
    play_round(2, 4'b0000);

    press(4'b0100);
    chk("a_step", lfsr_step, 1);
    chk("a_busy", busy, 1);
    @(negedge clk);
    press(4'b1000);
    chk("lose", lose, 1);
    chk("lose_busy", busy, 0);
    chk("lose_round", round, 2);
    chk("lose_led", led, 0);
    press(4'b0001);
    press(4'b0100);
    chk("lose_hold", lose, 1);
    chk("lose_hold_round", round, 2);
    chk("lose_nostep", lfsr_step, 0);
    pulse_start();
    chk("idle_round", round, 0);
    chk("idle_lose", lose, 0);
    chk("idle_rand2", lfsr_randomize, 1);

    pulse_start();
    play_round(1, 4'b0000);
    press(4'b0100);
    chk("b_step", lfsr_step, 1);
    play_round(2, 4'b0001);
    chk("noise_round", round, 2);
    press(4'b0100);
    @(negedge clk);
    press(4'b0001);
    chk("win", win, 1);
    chk("win_led", led, 4'b1111);
    chk("win_busy", busy, 0);
    chk("win_round", round, 2);
    chk("win_lose", lose, 0);
    pulse_start();
    chk("w_idle_round", round, 0);
    chk("w_idle_win", win, 0);
    chk("w_idle_rand", lfsr_randomize, 1);

    pulse_start();
    play_round(1, 4'b0000);
    press(4'b0101);
    chk("multi_lose", lose, 1);
    chk("multi_round", round, 1);
    pulse_start();

    pulse_start();
    for (int t = 0; t < 20 && led == 4'b0000; t++) @(negedge clk);
    chk("pre_rst_led", led, 4'b0100);
    #2;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_outs", {lfsr_step, lfsr_rerun, lfsr_randomize, led, busy, win, lose}, 0);
    chk("arst_round", round, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rel_rand", lfsr_randomize, 1);
    chk("rel_busy", busy, 0);

    pulse_start();
    play_round(1, 4'b0000);
`ifdef SIMON_TIMEOUT_EN
    repeat (TO - 1) @(negedge clk);
    chk("to_pre", lose, 0);
    @(negedge clk);
    chk("to_lose", lose, 1);
    chk("to_busy", busy, 0);
`else
    repeat (40) @(negedge clk);
    chk("nto_lose", lose, 0);
    chk("nto_busy", busy, 1);
    press(4'b0100);
    chk("nto_step", lfsr_step, 1);
    chk("nto_round", round, 2);
`endif

    chk("no_conflict", conflicts, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
